display_timer_ctrl: RTL
=======================

# display_timer_ctrl

Controller that sequences the two-digit BCD datapath feeding the pair of 7-segment displays as a countdown timer. It turns debounced, edge-detected button pulses into a preset (00–99), a 1-tick-per-second countdown, pause/resume and an expiry blink. It sits between the debounce/edge-detect front end and the two `Binary_To_7Segment` instances, driving their digit inputs and a blank control.

## Interface
- `CLKS_PER_TICK`, 25_000_000, clocks per countdown step (1 s at 25 MHz); must be ≥2.
- `CLKS_PER_BLINK`, 12_500_000, clocks per blink half-period in DONE; must be ≥2.

- `i_Clk` in 1: the single clock; all logic on its rising edge.
- `i_Rst_L` in 1: reset, synchronous, active-low.
- `i_Start_Pulse` in 1: one-cycle pulse that starts, pauses or resumes.
- `i_Inc_Pulse` in 1: one-cycle pulse that increments the preset (IDLE only).
- `i_Clear_Pulse` in 1: one-cycle pulse that aborts to IDLE with value 00.
- `o_Tens` out 4: BCD tens digit, 0–9.
- `o_Ones` out 4: BCD ones digit, 0–9.
- `o_Blank` out 1: 1 = downstream drives all segments off.
- `o_State` out 2: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- `o_Done` out 1: one-cycle pulse on expiry.

## Operation
- **Reset** (`i_Rst_L`=0 at an edge): state IDLE, `o_Tens`=`o_Ones`=0, preset register 00, tick counter 0, blink counter 0, `o_Blank`=0, `o_Done`=0.
- **Input priority** on the same cycle: Clear > Start > Inc. Lower-priority pulses that cycle are dropped.
- **Clear**, from any state: go to IDLE, digits 00, preset 00, `o_Blank`=0, counters 0.
- **IDLE**
  - Inc adds 1 in BCD: ones 9→0 with tens+1, and 99 wraps to 00. The result is also copied to the preset register.
  - Start with value ≠00: go to RUN with tick counter 0.
  - Start with value 00: ignored.
- **RUN**
  - Tick counter counts 0..`CLKS_PER_TICK`-1. At terminal count it wraps to 0 and the value decrements in BCD: ones 0→9 with tens-1.
  - If the decrement result is 00: go to DONE on the same edge, pulse `o_Done` for one cycle, and zero the blink counter.
  - Start: go to PAUSE. The tick counter is held, not cleared.
  - Inc: ignored.
- **PAUSE**
  - Value and tick counter frozen.
  - Start: return to RUN, continuing from the held tick count.
  - Inc: ignored.
- **DONE**
  - Digits 00.
  - Blink counter counts 0..`CLKS_PER_BLINK`-1 and toggles `o_Blank` at terminal count. The first half-period is visible (`o_Blank`=0).
  - Start: go to IDLE, reload digits from the preset register, `o_Blank`=0.
  - Inc: ignored.
- `o_Blank` is 0 in every state except DONE.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- A pulse sampled at edge n is reflected on the outputs after edge n (visible in cycle n+1).
- RUN step period is exactly `CLKS_PER_TICK` clocks. The first decrement occurs `CLKS_PER_TICK` edges after the edge that entered RUN. Time spent in PAUSE is excluded.
- Preset P (≠00) reaches DONE after exactly P×`CLKS_PER_TICK` RUN clocks.
- `o_Done` is high for exactly one cycle: the cycle in which `o_State` first reads DONE.
- Reset taken mid-RUN or mid-DONE overrides all pulses on that edge; all outputs hold their reset values from the next cycle on.
- Digits never take a non-BCD value (10–15) in any state.

## Structure
- The shared package `display_pkg` holds:
  - the state encoding constants (IDLE/RUN/PAUSE/DONE, 2 bits);
  - the BCD digit width (4);
  - the constants BCD_MAX=9 and TWO_DIGIT_MAX=99.
- One sub-module, `bcd_pair_step`: combinational. Inputs are tens, ones, inc and dec. Outputs are the next tens and ones, wrapping 99↔00 on inc/dec. The FSM instantiates it once.
- Both counters and all FSM logic live in `display_timer_ctrl`.

## Test plan
Bench parameters: `CLKS_PER_TICK`=4, `CLKS_PER_BLINK`=3.

- **Reset and wrap:** reset, then 100 Inc pulses. After pulse 9: `o_Tens`/`o_Ones`=0/9. After pulse 10: 1/0. After pulse 99: 9/9. After pulse 100: 0/0. `o_State` stays 0 throughout.
- **Countdown:** preset 03, then Start.
  - Decrements to 02, 01, 00 at 4, 8 and 12 edges after RUN entry.
  - `o_State`=3 and `o_Done`=1 for exactly one cycle at the 12th edge.
  - `o_Blank` pattern from DONE entry: 0,0,0,1,1,1,0…
  - Start in DONE: back to IDLE, digits 03, `o_Blank`=0.
- **Pause:** preset 02. Start, wait 2 clocks, Start (PAUSE), hold 20 clocks, Start (RUN).
  - Value stays 02 throughout the pause.
  - The first decrement lands 2 clocks after resume.
- **Priority and ignore:**
  - Clear+Start+Inc on the same cycle in RUN at value 05: IDLE, 00.
  - Start+Inc on the same cycle in IDLE at value 04: RUN, value stays 04.
  - Start at value 00 in IDLE: state remains 0.
- **Reset mid-operation:** assert `i_Rst_L`=0 for 1 cycle mid-RUN at value 07, and separately mid-DONE while `o_Blank`=1. Every output returns to its reset value on the next cycle. A following Start is ignored because the value is 00.
- **BCD invariant:** random pulses for 10k cycles. Assert `o_Tens`≤9, `o_Ones`≤9, and `o_Done` never high two cycles in a row.

Source files
------------

// File: rtl/display_pkg.sv
// Shared encodings and constants for the two-digit BCD countdown display controller.
package display_pkg;

   localparam int DIGIT_W       = 4;
   localparam int BCD_MAX       = 9;
   localparam int TWO_DIGIT_MAX = 99;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/display_timer_ctrl_if.sv
// Button-pulse inputs and display-facing outputs of the countdown timer controller.
interface display_timer_ctrl_if;
   import display_pkg::*;

   logic               i_Start_Pulse;
   logic               i_Inc_Pulse;
   logic               i_Clear_Pulse;
   logic [DIGIT_W-1:0] o_Tens;
   logic [DIGIT_W-1:0] o_Ones;
   logic               o_Blank;
   logic [1:0]         o_State;
   logic               o_Done;

   modport master (
      output i_Start_Pulse, i_Inc_Pulse, i_Clear_Pulse,
      input  o_Tens, o_Ones, o_Blank, o_State, o_Done
   );

   modport slave (
      input  i_Start_Pulse, i_Inc_Pulse, i_Clear_Pulse,
      output o_Tens, o_Ones, o_Blank, o_State, o_Done
   );

endinterface

// File: rtl/bcd_pair_step.sv
// Combinational +1 / -1 on a two-digit BCD value, wrapping 99 <-> 00.
module bcd_pair_step
   import display_pkg::*;
(
   input  logic [DIGIT_W-1:0] i_tens,
   input  logic [DIGIT_W-1:0] i_ones,
   input  logic               i_inc,
   input  logic               i_dec,
   output logic [DIGIT_W-1:0] o_tens,
   output logic [DIGIT_W-1:0] o_ones
);

   localparam logic [DIGIT_W-1:0] DIG_MAX = DIGIT_W'(BCD_MAX);

   always_comb begin
      o_tens = i_tens;
      o_ones = i_ones;
      if (i_inc && !i_dec) begin
         if (i_ones == DIG_MAX) begin
            o_ones = '0;
            o_tens = (i_tens == DIG_MAX) ? '0 : i_tens + 1'b1;
         end else begin
            o_ones = i_ones + 1'b1;
         end
      end else if (i_dec && !i_inc) begin
         if (i_ones == '0) begin
            o_ones = DIG_MAX;
            o_tens = (i_tens == '0) ? DIG_MAX : i_tens - 1'b1;
         end else begin
            o_ones = i_ones - 1'b1;
         end
      end
   end

endmodule

// File: rtl/display_timer_ctrl.sv
// Countdown timer FSM driving two BCD digits, a blank control and an expiry pulse.
//   state | meaning
//   IDLE  | preset editing with Inc; Start launches if value != 00
//   RUN   | one BCD decrement every CLKS_PER_TICK clocks
//   PAUSE | value and tick count frozen until Start
//   DONE  | digits 00, o_Blank toggles every CLKS_PER_BLINK clocks
module display_timer_ctrl
   import display_pkg::*;
#(
   parameter int CLKS_PER_TICK  = 25_000_000,
   parameter int CLKS_PER_BLINK = 12_500_000
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_L,
   display_timer_ctrl_if.slave  bus
);

   localparam int TICK_W  = (CLKS_PER_TICK  > 1) ? $clog2(CLKS_PER_TICK)  : 1;
   localparam int BLINK_W = (CLKS_PER_BLINK > 1) ? $clog2(CLKS_PER_BLINK) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(CLKS_PER_TICK - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(CLKS_PER_BLINK - 1);

   state_e               state_q, state_d;
   logic [DIGIT_W-1:0]   tens_q, tens_d, ones_q, ones_d;
   logic [DIGIT_W-1:0]   pre_tens_q, pre_tens_d, pre_ones_q, pre_ones_d;
   logic [TICK_W-1:0]    tick_q, tick_d;
   logic [BLINK_W-1:0]   blink_q, blink_d;
   logic                 blank_q, blank_d;
   logic                 done_q, done_d;

   logic                 clr, start, inc;
   logic                 step_inc, step_dec, step_zero;
   logic [DIGIT_W-1:0]   step_tens, step_ones;

   assign clr   = bus.i_Clear_Pulse;
   assign start = bus.i_Start_Pulse && !clr;
   assign inc   = bus.i_Inc_Pulse && !clr && !bus.i_Start_Pulse;

   assign step_inc  = (state_q == ST_IDLE) && inc;
   assign step_dec  = (state_q == ST_RUN) && !clr && !start && (tick_q == TICK_LAST);
   assign step_zero = (step_tens == '0) && (step_ones == '0);

   bcd_pair_step u_step (
      .i_tens (tens_q),
      .i_ones (ones_q),
      .i_inc  (step_inc),
      .i_dec  (step_dec),
      .o_tens (step_tens),
      .o_ones (step_ones)
   );

   always_comb begin
      state_d    = state_q;
      tens_d     = tens_q;
      ones_d     = ones_q;
      pre_tens_d = pre_tens_q;
      pre_ones_d = pre_ones_q;
      tick_d     = tick_q;
      blink_d    = blink_q;
      blank_d    = 1'b0;
      done_d     = 1'b0;

      if (clr) begin
         state_d    = ST_IDLE;
         tens_d     = '0;
         ones_d     = '0;
         pre_tens_d = '0;
         pre_ones_d = '0;
         tick_d     = '0;
         blink_d    = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if ((tens_q != '0) || (ones_q != '0)) begin
                     state_d = ST_RUN;
                     tick_d  = '0;
                  end
               end else if (inc) begin
                  tens_d     = step_tens;
                  ones_d     = step_ones;
                  pre_tens_d = step_tens;
                  pre_ones_d = step_ones;
               end
            end
            ST_RUN: begin
               // Start wins over a coincident terminal count; the tick is held.
               if (start) begin
                  state_d = ST_PAUSE;
               end else if (step_dec) begin
                  tick_d = '0;
                  tens_d = step_tens;
                  ones_d = step_ones;
                  if (step_zero) begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                     blink_d = '0;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
            ST_PAUSE: begin
               if (start) state_d = ST_RUN;
            end
            ST_DONE: begin
               if (start) begin
                  state_d = ST_IDLE;
                  tens_d  = pre_tens_q;
                  ones_d  = pre_ones_q;
               end else begin
                  tens_d = '0;
                  ones_d = '0;
                  if (blink_q == BLINK_LAST) begin
                     blink_d = '0;
                     blank_d = !blank_q;
                  end else begin
                     blink_d = blink_q + 1'b1;
                     blank_d = blank_q;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_Clk) begin
      if (!i_Rst_L) begin
         state_q    <= ST_IDLE;
         tens_q     <= '0;
         ones_q     <= '0;
         pre_tens_q <= '0;
         pre_ones_q <= '0;
         tick_q     <= '0;
         blink_q    <= '0;
         blank_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tens_q     <= tens_d;
         ones_q     <= ones_d;
         pre_tens_q <= pre_tens_d;
         pre_ones_q <= pre_ones_d;
         tick_q     <= tick_d;
         blink_q    <= blink_d;
         blank_q    <= blank_d;
         done_q     <= done_d;
      end
   end

   assign bus.o_Tens  = tens_q;
   assign bus.o_Ones  = ones_q;
   assign bus.o_Blank = blank_q;
   assign bus.o_State = state_q;
   assign bus.o_Done  = done_q;

endmodule
